mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the MEM-stage load/store requester. Data accesses have fixed priority, with a bounded-streak guard so fetch cannot starve. Requests are granted with zero added latency. Responses are routed back to the owner one cycle later, so back-to-back grants every cycle are sustained. Sits between the IF/MEM stages and the memory model or bus adapter.

## Interface
- STREAK_MAX, 4: max consecutive data grants while fetch is waiting; range 1..15.
- ADDR_W, 32: address width.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request (read-only)
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- d_req_i  in  1  data request
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  32  store data
- d_we_i  in  4  byte write enables; 0 = load
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response; pulses for loads and stores
- d_rdata_o  out  32  load data
- mem_req_o  out  1  memory access this cycle
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_we_o  out  4  memory byte enables
- mem_rdata_i  in  32  read data, valid the cycle after mem_req_o

## Operation
- Requesters hold req and payload stable until they see gnt high. Once gnt is seen, req may drop or present a new access.
- Arbitration is combinational each cycle:
  - only d_req: grant data.
  - only if_req: grant fetch.
  - both: grant data, unless streak_cnt == STREAK_MAX, in which case grant fetch.
- streak_cnt (4 bits) updates as follows:
  - increments on a data grant while if_req_i is high.
  - clears on any fetch grant, or any cycle with if_req_i low.
  - never exceeds STREAK_MAX.
- The granted requester's payload muxes onto mem_*_o. mem_req_o = if_gnt_o | d_gnt_o. When idle, mem_we_o = 0.
- Outstanding register: resp_owner ∈ {NONE, IF, D}. It is loaded every cycle with the owner granted that cycle, or NONE.
- Response cycle:
  - resp_owner == IF: if_rvalid_o = 1, if_rdata_o = mem_rdata_i.
  - resp_owner == D: d_rvalid_o = 1, d_rdata_o = mem_rdata_i. For stores, d_rdata_o is don't-care.
- rdata outputs are 0 when their rvalid is low.
- Only one grant per cycle, so if_gnt_o & d_gnt_o is never 1.

## Timing
- Grant: same cycle as req (combinational from req_i and streak_cnt).
- Response: exactly 1 cycle after grant. Throughput is 1 access per cycle with no bubbles.
- Reset (synchronous, on rst high at a clock edge):
  - resp_owner = NONE and streak_cnt = 0.
  - while rst is high, all gnt, rvalid, mem_req and mem_we outputs are 0 and rdata is 0.
  - a response owed for a grant made in the cycle before reset is dropped (rvalid stays 0).
- Same-cycle response and new grant to the same requester is legal: rvalid for the old access and gnt for the new one are both high.
- STREAK_MAX = 1 strictly alternates under continuous contention.

## Structure
- Package mem_arb_pkg: enum resp_owner_e {OWN_NONE, OWN_IF, OWN_D}; constant STREAK_W = 4.
- A single module is sufficient. An optional pure-combinational sub-module mem_arb_pick (priority plus streak decision) may be split out for unit testing.

## Test plan
- Fetch only: if_req with addr 0x100 then 0x104 on consecutive cycles. Expect if_gnt both cycles, mem_addr 0x100 then 0x104, and if_rvalid on the following two cycles with data 0x11111111 then 0x22222222.
- Load vs fetch, STREAK_MAX = 4, both requesting continuously:
  - grant pattern D,D,D,D,IF repeating.
  - each d_rvalid/if_rvalid arrives exactly 1 cycle after its grant.
- Store: d_we = 4'b0011, d_addr 0x200, d_wdata 0xDEADBEEF. Expect mem_we 4'b0011 and mem_wdata 0xDEADBEEF in the grant cycle, and d_rvalid 1 cycle later. No if_rvalid.
- Streak clear: D,D while fetch waits, then if_req drops for one cycle, then returns. Expect the counter reset, with four more data grants before fetch wins.
- Reset mid-access: grant a data load at cycle N, assert rst at cycle N+1. Expect d_rvalid = 0 at N+1, all outputs 0 during reset, and normal grants resuming the cycle after rst falls.
- Invariant check: random req/addr over 10k cycles. Gnts are never both high, every grant produces exactly one rvalid to the same owner, and fetch wait never exceeds STREAK_MAX cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
//   STREAK_W     : width of the data-grant streak counter
//   resp_owner_e : which requester owns the response arriving next cycle
package mem_arb_pkg;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } resp_owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Pure combinational grant decision for the memory port.
//   if_req_i / d_req_i : qualified requests (already masked by reset)
//   streak_cnt_i       : consecutive data grants while fetch has been waiting
//   if_gnt_o / d_gnt_o : one-hot (or zero) grant
// Data wins by default; fetch wins once the streak has hit STREAK_MAX.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_cnt_i,
  output logic                if_gnt_o,
  output logic                d_gnt_o
);
  logic fetch_due;

  always_comb begin
    fetch_due = if_req_i && (streak_cnt_i == STREAK_W'(STREAK_MAX));
    d_gnt_o   = d_req_i && !fetch_due;
    if_gnt_o  = if_req_i && !d_gnt_o;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the
// MEM-stage load/store requester.
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   if_req/if_addr           : fetch request, granted via if_gnt_o
//   if_rvalid/if_rdata       : fetch response, one cycle after the grant
//   d_req/d_addr/d_wdata/d_we: data request (d_we == 0 is a load)
//   d_rvalid/d_rdata         : data response, one cycle after the grant
//   mem_*                    : memory port; mem_rdata_i valid the cycle after mem_req_o
// Grants are combinational (zero added latency), so one access per cycle is
// sustained; the response owner is tracked in a single register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_we_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_we_o,
  input  logic [31:0]       mem_rdata_i
);
  logic [STREAK_W-1:0] streak_cnt_d, streak_cnt_q;
  resp_owner_e         resp_owner_d, resp_owner_q;
  logic                if_req_q, d_req_q;
  logic                if_gnt, d_gnt;

  // Requests are masked during reset so nothing is granted while rst is high.
  assign if_req_q = if_req_i & ~rst;
  assign d_req_q  = d_req_i & ~rst;

  mem_arb_pick #(.STREAK_MAX(STREAK_MAX)) u_pick (
    .if_req_i     (if_req_q),
    .d_req_i      (d_req_q),
    .streak_cnt_i (streak_cnt_q),
    .if_gnt_o     (if_gnt),
    .d_gnt_o      (d_gnt)
  );

  always_comb begin
    if_gnt_o    = if_gnt;
    d_gnt_o     = d_gnt;
    mem_req_o   = if_gnt | d_gnt;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    if (d_gnt) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_we_o    = d_we_i;
    end else if (if_gnt) begin
      mem_addr_o  = if_addr_i;
    end

    // Streak only counts data wins while fetch is actually waiting.
    streak_cnt_d = streak_cnt_q;
    if (if_gnt || !if_req_i)
      streak_cnt_d = '0;
    else if (d_gnt && (streak_cnt_q < STREAK_W'(STREAK_MAX)))
      streak_cnt_d = streak_cnt_q + 1'b1;

    resp_owner_d = OWN_NONE;
    if (d_gnt)       resp_owner_d = OWN_D;
    else if (if_gnt) resp_owner_d = OWN_IF;

    // A response owed across a reset edge is dropped: rvalid is masked by rst.
    if_rvalid_o = !rst && (resp_owner_q == OWN_IF);
    d_rvalid_o  = !rst && (resp_owner_q == OWN_D);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_cnt_q <= '0;
      resp_owner_q <= OWN_NONE;
    end else begin
      streak_cnt_q <= streak_cnt_d;
      resp_owner_q <= resp_owner_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter. A reference grant model and a
// response scoreboard (expected responses queued at grant, popped one cycle
// later) are checked every cycle on the falling edge.
module tb_mem_port_arbiter;
  localparam int STREAK_MAX = 4;
  localparam int ADDR_W     = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o, if_rvalid_o;
  logic [31:0]       if_rdata_o;
  logic              d_req_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [3:0]        d_we_i;
  logic              d_gnt_o, d_rvalid_o;
  logic [31:0]       d_rdata_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_we_o;
  logic [31:0]       mem_rdata_i = 32'h0;

  mem_port_arbiter #(.STREAK_MAX(STREAK_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_we_i(d_we_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [ADDR_W-1:0] a);
    if (a == 32'h100)      return 32'h1111_1111;
    else if (a == 32'h104) return 32'h2222_2222;
    else                   return {a[15:0], ~a[31:16]};
  endfunction

  // Memory: read data for a granted load appears the cycle after the request.
  always @(posedge clk)
    mem_rdata_i <= (mem_req_o && mem_we_o == 4'h0) ? mem_val(mem_addr_o) : 32'h0;

  typedef struct {
    logic        is_d;
    logic        is_store;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_streak = 0;
  int   if_wait = 0;
  logic exp_if, exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge, update the reference model at posedge,
  // leave 1 time unit for the caller to drive the next inputs.
  task automatic cycle();
    exp_t e;
    bit   have;
    @(negedge clk);
    exp_if = 1'b0;
    exp_d  = 1'b0;
    if (!rst) begin
      if (d_req_i && !(if_req_i && m_streak == STREAK_MAX)) exp_d = 1'b1;
      else if (if_req_i)                                    exp_if = 1'b1;
    end
    chk("if_gnt",  if_gnt_o,  exp_if);
    chk("d_gnt",   d_gnt_o,   exp_d);
    chk("mem_req", mem_req_o, exp_if | exp_d);
    chk("mem_we",  mem_we_o,  exp_d ? d_we_i : 4'h0);
    if (exp_d) begin
      chk("mem_addr_d", mem_addr_o, d_addr_i);
      if (d_we_i != 4'h0) chk("mem_wdata", mem_wdata_o, d_wdata_i);
    end else if (exp_if) begin
      chk("mem_addr_if", mem_addr_o, if_addr_i);
    end

    have = (sb_q.size() > 0);
    if (have) e = sb_q.pop_front();
    if (have && !rst) begin
      chk("if_rvalid", if_rvalid_o, !e.is_d);
      chk("d_rvalid",  d_rvalid_o,  e.is_d);
      if (e.is_d) begin
        if (!e.is_store) chk("d_rdata", d_rdata_o, e.data);
        chk("if_rdata_idle", if_rdata_o, 32'h0);
      end else begin
        chk("if_rdata", if_rdata_o, e.data);
        chk("d_rdata_idle", d_rdata_o, 32'h0);
      end
    end else begin
      chk("if_rvalid_idle", if_rvalid_o, 1'b0);
      chk("d_rvalid_idle",  d_rvalid_o,  1'b0);
      chk("if_rdata_idle",  if_rdata_o,  32'h0);
      chk("d_rdata_idle",   d_rdata_o,   32'h0);
    end

    if (exp_d)       sb_q.push_back('{1'b1, d_we_i != 4'h0, mem_val(d_addr_i)});
    else if (exp_if) sb_q.push_back('{1'b0, 1'b0, mem_val(if_addr_i)});

    // Fetch starvation bound, measured on the DUT's own grants.
    if (rst || !if_req_i || if_gnt_o) if_wait = 0;
    else begin
      if_wait++;
      chk("if_wait_bound", 32'(if_wait <= STREAK_MAX), 32'd1);
    end

    @(posedge clk);
    if (rst || exp_if || !if_req_i)           m_streak = 0;
    else if (exp_d && m_streak < STREAK_MAX)  m_streak++;
    #1;
  endtask

  // Advance the payload of whichever requester was granted.
  task automatic advance();
    if (exp_d)  d_addr_i  = d_addr_i + 32'd4;
    if (exp_if) if_addr_i = if_addr_i + 32'd4;
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_we_i = 4'h0;
    cycle();
    // Requests during reset must not be granted.
    if_req_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h40;
    cycle();
    rst = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();

    // Fetch only, back to back.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    cycle();
    chk("fetch0_gnt", if_gnt_o, 1'b1);
    if_addr_i = 32'h104;
    cycle();
    if_req_i = 1'b0;
    cycle();
    cycle();

    // Continuous contention: D,D,D,D,IF repeating.
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    d_req_i = 1'b1; d_addr_i = 32'h2000; d_we_i = 4'h0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("contend_pattern_if", exp_if, 32'((i % 5) == 4));
      advance();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();
    cycle();

    // Store: byte enables and write data on the port, d_rvalid one cycle later.
    d_req_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_we_i = 4'b0011;
    cycle();
    d_req_i = 1'b0; d_we_i = 4'h0; d_wdata_i = '0;
    cycle();
    cycle();

    // Streak clear: D,D with fetch waiting, fetch drops once, then 4 more D before IF.
    if_req_i = 1'b1; if_addr_i = 32'h3000;
    d_req_i = 1'b1; d_addr_i = 32'h4000;
    cycle(); advance();
    cycle(); advance();
    if_req_i = 1'b0;
    cycle(); advance();
    if_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("clear_pattern_if", exp_if, 32'(i == 4));
      advance();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();
    cycle();

    // Reset mid-access: owed load response is dropped, grants resume after reset.
    d_req_i = 1'b1; d_addr_i = 32'h300;
    cycle();
    rst = 1'b1; d_addr_i = 32'h304; if_req_i = 1'b1; if_addr_i = 32'h500;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_reset_d_gnt", d_gnt_o, 1'b1);
    advance();
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();
    cycle();

    // Random traffic honouring hold-until-grant.
    for (int n = 0; n < 10000; n++) begin
      if (!if_req_i || exp_if) begin
        if_req_i  = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_req_i || exp_d) begin
        d_req_i   = ($urandom_range(0, 3) != 0);
        d_addr_i  = $urandom() & 32'hFFFF_FFFC;
        d_wdata_i = $urandom();
        d_we_i    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      cycle();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();
    cycle();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
